// File: rtl/burst_bus_slave_pkg.sv
// Shared types and constants for the burst bus target: FSM states, error reasons,
// beat-counter width and the window range helper.
package burst_bus_slave_pkg;

   localparam int MEM_WORDS_LOG2_DFLT = 9;
   localparam int BURST_W             = 8;
   // Beat count holds burst_size + 1, so one bit wider than the burst field.
   localparam int BEAT_W              = BURST_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      READ_END,
      WRITE,
      DRAIN
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_MISALIGNED,
      ERR_RANGE,
      ERR_OVERRUN
   } err_t;

   // True when every beat of the burst lands inside the SRAM.
   function automatic logic burst_fits(input logic [31:0] first_word,
                                       input logic [BURST_W-1:0] burst,
                                       input int words_log2);
      return (first_word + 32'(burst)) < (32'd1 << words_log2);
   endfunction

endpackage

// File: rtl/burst_bus_slave_ram.sv
// Single-port word SRAM with per-byte write enables and a one-cycle registered read.
// Contents are never reset.
module burst_bus_slave_ram #(
   parameter int ADDR_W = 9
) (
   input  logic              clock,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd_en,
   input  logic [3:0]        wr_be,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   always_ff @(posedge clock) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (rd_en) rdata <= mem[addr];
   end

endmodule

// File: rtl/burst_bus_slave.sv
// Burst bus target backed by a local SRAM: decodes its window, streams reads, absorbs writes.
// Optional write backpressure is enabled with `define BURST_BUS_SLAVE_BACKPRESSURE_EN.
module burst_bus_slave
   import burst_bus_slave_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS   = 32'h5000_0000,
   parameter int          MEM_WORDS_LOG2 = MEM_WORDS_LOG2_DFLT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               begin_transaction_in,
   input  logic [31:0]        address_data_in,
   input  logic               read_n_write_in,
   input  logic [BURST_W-1:0] burst_size_in,
   input  logic [3:0]         byte_enables_in,
   input  logic               data_valid_in,
   input  logic               end_transaction_in,
   output logic [31:0]        address_data_out,
   output logic               data_valid_out,
   output logic               end_transaction_out,
   output logic               busy_out,
   output logic               error_out
);

   localparam int INDEX_W = MEM_WORDS_LOG2;

   logic               in_window;
   logic               misaligned;
   logic [INDEX_W-1:0] begin_index;

   assign in_window   = address_data_in[31:INDEX_W+2] == BASE_ADDRESS[31:INDEX_W+2];
   assign misaligned  = |address_data_in[1:0];
   assign begin_index = address_data_in[INDEX_W+1:2];

   state_t              state, state_next;
   logic [INDEX_W-1:0]  index, index_next;
   logic [BEAT_W-1:0]   beats_left, beats_left_next;
   err_t                err_code;
   logic                issue;
   logic                accept;
   logic                end_pulse;
   logic                start;
   logic                busy;
   logic                vld_p1;
   logic                err_p1;
   logic                end_p1;
   logic [31:0]         ram_q_p1;

   always_comb begin
      state_next      = state;
      index_next      = index;
      beats_left_next = beats_left;
      err_code        = ERR_NONE;
      issue           = 1'b0;
      accept          = 1'b0;
      end_pulse       = 1'b0;
      start           = 1'b0;
      case (state)
         IDLE: begin
            if (begin_transaction_in && in_window) begin
               if (misaligned) begin
                  err_code   = ERR_MISALIGNED;
                  state_next = DRAIN;
               end else if (!burst_fits(32'(begin_index), burst_size_in, MEM_WORDS_LOG2)) begin
                  err_code   = ERR_RANGE;
                  state_next = DRAIN;
               end else begin
                  start           = 1'b1;
                  index_next      = begin_index;
                  beats_left_next = BEAT_W'(burst_size_in) + BEAT_W'(1);
                  state_next      = read_n_write_in ? READ : WRITE;
               end
            end
         end
         READ: begin
            if (end_transaction_in) begin
               state_next = IDLE;
            end else begin
               issue           = 1'b1;
               index_next      = index + INDEX_W'(1);
               beats_left_next = beats_left - BEAT_W'(1);
               if (beats_left == BEAT_W'(1)) state_next = READ_END;
            end
         end
         READ_END: begin
            end_pulse  = !end_transaction_in;
            state_next = IDLE;
         end
         WRITE: begin
            if (data_valid_in && !busy) begin
               if (beats_left == '0) begin
                  err_code   = ERR_OVERRUN;
                  state_next = DRAIN;
               end else begin
                  accept          = 1'b1;
                  index_next      = index + INDEX_W'(1);
                  beats_left_next = beats_left - BEAT_W'(1);
               end
            end
            // A short write is legal: end closes the transaction at any beat.
            if (end_transaction_in) state_next = IDLE;
         end
         DRAIN: begin
            if (end_transaction_in) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         index      <= '0;
         beats_left <= '0;
         vld_p1     <= 1'b0;
         err_p1     <= 1'b0;
         end_p1     <= 1'b0;
      end else begin
         state      <= state_next;
         index      <= index_next;
         beats_left <= beats_left_next;
         vld_p1     <= issue;
         err_p1     <= err_code != ERR_NONE;
         end_p1     <= end_pulse;
      end
   end

`ifdef BURST_BUS_SLAVE_BACKPRESSURE_EN
   // One stall cycle follows every fourth accepted beat of a transaction.
   logic [1:0] accept_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         busy       <= 1'b0;
         accept_cnt <= '0;
      end else begin
         busy <= accept && (accept_cnt == 2'd3);
         if (start)       accept_cnt <= '0;
         else if (accept) accept_cnt <= accept_cnt + 2'd1;
      end
   end
`else
   assign busy = 1'b0;
`endif

   // ---- stage p1: SRAM read data registered one cycle after issue ----
   burst_bus_slave_ram #(
      .ADDR_W (INDEX_W)
   ) u_ram (
      .clock (clock),
      .addr  (index),
      .rd_en (issue),
      .wr_be (accept ? byte_enables_in : 4'b0000),
      .wdata (address_data_in),
      .rdata (ram_q_p1)
   );

   assign address_data_out    = vld_p1 ? ram_q_p1 : '0;
   assign data_valid_out      = vld_p1;
   assign end_transaction_out = end_p1;
   assign busy_out            = busy;
   assign error_out           = err_p1;

endmodule

// File: tb/tb_burst_bus_slave.sv
// Randomized self-checking bench for burst_bus_slave against a word-array memory model.
// Backpressure checks follow `define BURST_BUS_SLAVE_BACKPRESSURE_EN.
module tb_burst_bus_slave;

   localparam logic [31:0] BASE  = 32'h5000_0000;
   localparam int          WORDS = 512;

   logic        clock = 1'b0;
   logic        reset;
   logic        begin_transaction_in;
   logic [31:0] address_data_in;
   logic        read_n_write_in;
   logic [7:0]  burst_size_in;
   logic [3:0]  byte_enables_in;
   logic        data_valid_in;
   logic        end_transaction_in;
   logic [31:0] address_data_out;
   logic        data_valid_out;
   logic        end_transaction_out;
   logic        busy_out;
   logic        error_out;

   burst_bus_slave #(
      .BASE_ADDRESS   (BASE),
      .MEM_WORDS_LOG2 (9)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .begin_transaction_in(begin_transaction_in),
      .address_data_in     (address_data_in),
      .read_n_write_in     (read_n_write_in),
      .burst_size_in       (burst_size_in),
      .byte_enables_in     (byte_enables_in),
      .data_valid_in       (data_valid_in),
      .end_transaction_in  (end_transaction_in),
      .address_data_out    (address_data_out),
      .data_valid_out      (data_valid_out),
      .end_transaction_out (end_transaction_out),
      .busy_out            (busy_out),
      .error_out           (error_out)
   );

   always #5 clock = ~clock;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mem_model [WORDS];
   logic [31:0] wbuf [256];
   logic [3:0]  wbe  [256];
   logic [31:0] rd_data [$];
   int          rd_off [$];
   int          busy_after [$];
   int          end_off;
   int          err_off;
   int          stray_out;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      begin_transaction_in = 1'b0;
      address_data_in      = '0;
      read_n_write_in      = 1'b0;
      burst_size_in        = '0;
      byte_enables_in      = '0;
      data_valid_in        = 1'b0;
      end_transaction_in   = 1'b0;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // Only the first bs+1 presented beats of a write land in memory.
   task automatic model_write(input int idx, input int bs, input int n);
      for (int k = 0; k < n && k <= bs; k++) mem_model[idx+k] = merge(mem_model[idx+k], wbuf[k], wbe[k]);
   endtask

   task automatic start_txn(input logic [31:0] addr, input logic rnw, input logic [7:0] bs);
      begin_transaction_in = 1'b1;
      address_data_in      = addr;
      read_n_write_in      = rnw;
      burst_size_in        = bs;
      tick();
      begin_transaction_in = 1'b0;
      address_data_in      = '0;
      read_n_write_in      = 1'b0;
      burst_size_in        = '0;
   endtask

   // Presents n beats from wbuf/wbe, holding a beat while busy_out is high, then ends.
   task automatic write_burst(input logic [31:0] addr, input logic [7:0] bs, input int n, input bit gaps);
      int c = 1;
      int k = 0;
      int guard = 0;
      err_off = -1;
      busy_after.delete();
      start_txn(addr, 1'b0, bs);
      while (k < n && guard < 4*n + 20) begin
         guard++;
         if (error_out && err_off < 0) err_off = c;
         if (busy_out) busy_after.push_back(k);
         if (gaps && $urandom_range(0, 3) == 0) begin
            data_valid_in = 1'b0;
         end else begin
            data_valid_in   = 1'b1;
            address_data_in = wbuf[k];
            byte_enables_in = wbe[k];
            if (!busy_out) k++;
         end
         tick();
         c++;
      end
      data_valid_in   = 1'b0;
      address_data_in = '0;
      byte_enables_in = '0;
      if (error_out && err_off < 0) err_off = c;
      if (busy_out) busy_after.push_back(k);
      end_transaction_in = 1'b1;
      tick();
      c++;
      end_transaction_in = 1'b0;
      if (error_out && err_off < 0) err_off = c;
      n_tests++;
      if (k !== n) begin
         n_fail++;
         $display("FAIL write_timeout: beats presented %0d, required %0d", k, n);
      end
   endtask

   // Collects read beats with their cycle offset from the begin cycle.
   task automatic read_burst(input logic [31:0] addr, input logic [7:0] bs, input int abort_at,
                             input bit stop_at_end);
      rd_data.delete();
      rd_off.delete();
      end_off   = -1;
      err_off   = -1;
      stray_out = 0;
      start_txn(addr, 1'b1, bs);
      for (int c = 1; c <= int'(bs) + 8; c++) begin
         if (data_valid_out) begin
            rd_data.push_back(address_data_out);
            rd_off.push_back(c);
         end else if (address_data_out !== 32'h0) begin
            stray_out++;
         end
         if (end_transaction_out && end_off < 0) end_off = c;
         if (error_out && err_off < 0) err_off = c;
         if (stop_at_end && end_transaction_out) break;
         end_transaction_in = abort_at > 0 && data_valid_out && rd_data.size() == abort_at;
         tick();
         end_transaction_in = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      n_tests++;
      if (data_valid_out !== 1'b0 || address_data_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: valid %b data %h, required 0 and 0", data_valid_out, address_data_out);
      end
      n_tests++;
      if ({end_transaction_out, busy_out, error_out} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: end/busy/err %b, required 000", {end_transaction_out, busy_out, error_out});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      for (int i = 0; i < WORDS; i++) mem_model[i] = '0;
      for (int k = 0; k < 256; k++) begin
         wbuf[k] = '0;
         wbe[k]  = 4'hF;
      end
      for (int h = 0; h < 2; h++) begin
         write_burst(BASE + 32'(h*1024), 8'd255, 256, 1'b0);
         n_tests++;
         if (err_off !== -1) begin
            n_fail++;
            $display("FAIL fill_error: error at offset %0d, required none", err_off);
         end
      end
   endtask

   task automatic test_write_read_burst();
      int idx = 4;
      for (int k = 0; k < 4; k++) begin
         wbuf[k] = 32'h11 * (k + 1);
         wbe[k]  = 4'hF;
      end
      write_burst(BASE + 32'h10, 8'd3, 4, 1'b0);
      model_write(idx, 3, 4);
      read_burst(BASE + 32'h10, 8'd3, 0, 1'b0);
      n_tests++;
      if (rd_data.size() !== 4) begin
         n_fail++;
         $display("FAIL burst_count: got %0d beats, required 4", rd_data.size());
      end
      for (int k = 0; k < rd_data.size() && k < 4; k++) begin
         n_tests++;
         if (rd_data[k] !== 32'h11 * (k + 1) || rd_off[k] !== k + 2) begin
            n_fail++;
            $display("FAIL burst_beat%0d: got %h at T+%0d, required %h at T+%0d",
                     k, rd_data[k], rd_off[k], 32'h11 * (k + 1), k + 2);
         end
      end
      n_tests++;
      if (end_off !== 6 || stray_out !== 0) begin
         n_fail++;
         $display("FAIL burst_end: end at T+%0d stray %0d, required T+6 stray 0", end_off, stray_out);
      end
   endtask

   task automatic test_partial_write();
      wbuf[0] = 32'hAABB_CCDD;
      wbe[0]  = 4'b0011;
      write_burst(BASE, 8'd0, 1, 1'b0);
      model_write(0, 0, 1);
      read_burst(BASE, 8'd0, 0, 1'b0);
      n_tests++;
      if (rd_data.size() !== 1 || rd_data[0] !== 32'h0000_CCDD || end_off !== 3) begin
         n_fail++;
         $display("FAIL partial_write: beats %0d data %h end T+%0d, required 1 0000ccdd T+3",
                  rd_data.size(), rd_data.size() > 0 ? rd_data[0] : 32'h0, end_off);
      end
   endtask

   task automatic test_decode_errors();
      logic [31:0] addr [3];
      logic [7:0]  bs   [3];
      int          exp_err [3];
      addr[0] = BASE + 32'h2;      bs[0] = 8'd0; exp_err[0] = 1;
      addr[1] = BASE + 32'd2040;   bs[1] = 8'd3; exp_err[1] = 1;
      addr[2] = BASE - 32'h4;      bs[2] = 8'd0; exp_err[2] = -1;
      for (int i = 0; i < 3; i++) begin
         read_burst(addr[i], bs[i], 0, 1'b0);
         n_tests++;
         if (err_off !== exp_err[i] || rd_data.size() !== 0 || end_off !== -1) begin
            n_fail++;
            $display("FAIL decode_%0d: err T+%0d beats %0d end %0d, required err %0d beats 0 end -1",
                     i, err_off, rd_data.size(), end_off, exp_err[i]);
         end
         end_transaction_in = 1'b1;
         tick();
         end_transaction_in = 1'b0;
      end
      read_burst(BASE + 32'd2032, 8'd3, 0, 1'b0);
      n_tests++;
      if (rd_data.size() !== 4 || end_off !== 6 || err_off !== -1) begin
         n_fail++;
         $display("FAIL decode_edge_ok: beats %0d end T+%0d err %0d, required 4 T+6 -1",
                  rd_data.size(), end_off, err_off);
      end
   endtask

   task automatic test_overrun();
      int idx = 32;
      for (int k = 0; k < 3; k++) begin
         wbuf[k] = $urandom;
         wbe[k]  = 4'hF;
      end
      write_burst(BASE + 32'(4*idx), 8'd1, 3, 1'b0);
      model_write(idx, 1, 3);
      n_tests++;
      if (err_off !== 4) begin
         n_fail++;
         $display("FAIL overrun_error: error at T+%0d, required T+4", err_off);
      end
      read_burst(BASE + 32'(4*idx), 8'd2, 0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (rd_data.size() !== 3 || rd_data[k] !== mem_model[idx+k]) begin
            n_fail++;
            $display("FAIL overrun_mem%0d: got %h (beats %0d), required %h",
                     k, rd_data.size() > k ? rd_data[k] : 32'h0, rd_data.size(), mem_model[idx+k]);
         end
      end
   endtask

   task automatic test_read_abort();
      int idx = 64;
      for (int k = 0; k < 8; k++) begin
         wbuf[k] = $urandom;
         wbe[k]  = 4'hF;
      end
      write_burst(BASE + 32'(4*idx), 8'd7, 8, 1'b0);
      model_write(idx, 7, 8);
      read_burst(BASE + 32'(4*idx), 8'd7, 3, 1'b0);
      n_tests++;
      if (rd_data.size() !== 3 || end_off !== -1) begin
         n_fail++;
         $display("FAIL abort: beats %0d end %0d, required 3 and -1", rd_data.size(), end_off);
      end
      for (int k = 0; k < rd_data.size() && k < 3; k++) begin
         n_tests++;
         if (rd_data[k] !== mem_model[idx+k]) begin
            n_fail++;
            $display("FAIL abort_data%0d: got %h, required %h", k, rd_data[k], mem_model[idx+k]);
         end
      end
   endtask

   task automatic test_reset_mid_write();
      int idx = 128;
      for (int k = 0; k < 4; k++) begin
         wbuf[k] = $urandom;
         wbe[k]  = 4'hF;
      end
      start_txn(BASE + 32'(4*idx), 1'b0, 8'd3);
      for (int k = 0; k < 2; k++) begin
         data_valid_in   = 1'b1;
         address_data_in = wbuf[k];
         byte_enables_in = wbe[k];
         tick();
      end
      idle_inputs();
      model_write(idx, 1, 2);
      reset = 1'b1;
      tick();
      n_tests++;
      if ({data_valid_out, end_transaction_out, busy_out, error_out} !== 4'b0000 ||
          address_data_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_write: flags %b data %h, required 0000 and 0",
                  {data_valid_out, end_transaction_out, busy_out, error_out}, address_data_out);
      end
      reset = 1'b0;
      tick();
      read_burst(BASE + 32'(4*idx), 8'd3, 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (rd_data.size() !== 4 || rd_data[k] !== mem_model[idx+k]) begin
            n_fail++;
            $display("FAIL reset_keep%0d: got %h (beats %0d), required %h",
                     k, rd_data.size() > k ? rd_data[k] : 32'h0, rd_data.size(), mem_model[idx+k]);
         end
      end
      read_burst(BASE + 32'h10, 8'd3, 0, 1'b0);
      n_tests++;
      if (rd_data.size() !== 4 || rd_data[3] !== mem_model[7]) begin
         n_fail++;
         $display("FAIL reset_old_data: beats %0d, required 4 with last %h", rd_data.size(), mem_model[7]);
      end
   endtask

   task automatic test_back_to_back();
      int idx = 192;
      wbuf[0] = $urandom; wbe[0] = 4'hF;
      wbuf[1] = $urandom; wbe[1] = 4'hF;
      write_burst(BASE + 32'(4*idx), 8'd1, 2, 1'b0);
      model_write(idx, 1, 2);
      read_burst(BASE + 32'(4*idx), 8'd1, 0, 1'b1);
      n_tests++;
      if (rd_data.size() !== 2 || rd_data[1] !== mem_model[idx+1] || end_off !== 4) begin
         n_fail++;
         $display("FAIL b2b_first: beats %0d end T+%0d, required 2 beats ending %h at T+4",
                  rd_data.size(), end_off, mem_model[idx+1]);
      end
      read_burst(BASE + 32'(4*idx), 8'd0, 0, 1'b0);
      n_tests++;
      if (rd_data.size() !== 1 || rd_data[0] !== mem_model[idx] || rd_off[0] !== 2) begin
         n_fail++;
         $display("FAIL b2b_second: beats %0d, required 1 beat %h at T+2", rd_data.size(), mem_model[idx]);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int bs  = $urandom_range(0, 15);
         int idx = $urandom_range(0, WORDS - 1 - bs);
         for (int k = 0; k <= bs; k++) begin
            wbuf[k] = $urandom;
            wbe[k]  = 4'($urandom_range(1, 15));
         end
         write_burst(BASE + 32'(4*idx), 8'(bs), bs + 1, 1'b1);
         model_write(idx, bs, bs + 1);
         read_burst(BASE + 32'(4*idx), 8'(bs), 0, 1'b0);
         n_tests++;
         if (rd_data.size() !== bs + 1 || end_off !== bs + 3 || err_off !== -1) begin
            n_fail++;
            $display("FAIL random%0d_shape: beats %0d end T+%0d err %0d, required %0d T+%0d -1",
                     it, rd_data.size(), end_off, err_off, bs + 1, bs + 3);
         end
         for (int k = 0; k < rd_data.size() && k <= bs; k++) begin
            n_tests++;
            if (rd_data[k] !== mem_model[idx+k]) begin
               n_fail++;
               $display("FAIL random%0d_word%0d: got %h, required %h", it, k, rd_data[k], mem_model[idx+k]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int idx = 224;
      for (int k = 0; k < 8; k++) begin
         wbuf[k] = $urandom;
         wbe[k]  = 4'hF;
      end
      write_burst(BASE + 32'(4*idx), 8'd7, 8, 1'b0);
      model_write(idx, 7, 8);
`ifdef BURST_BUS_SLAVE_BACKPRESSURE_EN
      n_tests++;
      if (busy_after.size() !== 2 || busy_after[0] !== 4 || busy_after[1] !== 8) begin
         n_fail++;
         $display("FAIL busy_pattern: %0d busy cycles (first after %0d beats), required 2 after beats 4 and 8",
                  busy_after.size(), busy_after.size() > 0 ? busy_after[0] : -1);
      end
`else
      n_tests++;
      if (busy_after.size() !== 0) begin
         n_fail++;
         $display("FAIL busy_idle: %0d busy cycles, required 0", busy_after.size());
      end
`endif
      read_burst(BASE + 32'(4*idx), 8'd7, 0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         n_tests++;
         if (rd_data.size() !== 8 || rd_data[k] !== mem_model[idx+k]) begin
            n_fail++;
            $display("FAIL bp_word%0d: got %h (beats %0d), required %h",
                     k, rd_data.size() > k ? rd_data[k] : 32'h0, rd_data.size(), mem_model[idx+k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_write_read_burst();
      test_partial_write();
      test_decode_errors();
      test_overrun();
      test_read_abort();
      test_reset_mid_write();
      test_back_to_back();
      test_random();
      test_backpressure();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
